// File: rtl/cond_unit_e.sv
// Execute-stage condition check, NZCV flags, enable gating and multicycle sequencing.
// Define COND_PERF_CNT_EN to build the condition-fail and stall performance counters.
module cond_unit_e #(
  parameter logic [3:0] FLAGS_INIT = 4'b0000,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             Stall,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWE,
  input  logic             PCSE,
  input  logic             RegWE,
  input  logic             MemWE,
  input  logic             NoWriteE,
  input  logic             M_StartE,
  input  logic             MCycleOpE,
  input  logic             MWriteE,
  input  logic [3:0]       ALUFlags,
  input  logic             MCycleDone,
  output logic             CondExE,
  output logic             PCSrcE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             MWriteGE,
  output logic             MStartO,
  output logic             MCycleOpO,
  output logic             MCycleStall,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] CondFailCnt,
  output logic [CNT_W-1:0] MStallCnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic n_f;
  logic z_f;
  logic c_f;
  logic v_f;
  logic adv;
  logic start;

  assign {n_f, z_f, c_f, v_f} = Flags;

  always_comb begin
    CondExE = 1'b1;
    case (CondE)
      4'h0: CondExE = z_f;
      4'h1: CondExE = !z_f;
      4'h2: CondExE = c_f;
      4'h3: CondExE = !c_f;
      4'h4: CondExE = n_f;
      4'h5: CondExE = !n_f;
      4'h6: CondExE = v_f;
      4'h7: CondExE = !v_f;
      4'h8: CondExE = c_f & !z_f;
      4'h9: CondExE = !c_f | z_f;
      4'hA: CondExE = (n_f == v_f);
      4'hB: CondExE = (n_f != v_f);
      4'hC: CondExE = !z_f & (n_f == v_f);
      4'hD: CondExE = z_f | (n_f != v_f);
      default: CondExE = 1'b1;
    endcase
  end

  assign PCSrcE    = PCSE & CondExE;
  assign RegWriteE = RegWE & CondExE & !NoWriteE;
  assign MemWriteE = MemWE & CondExE;
  assign MWriteGE  = MWriteE & CondExE & (state == DONE);
  assign MCycleOpO = MCycleOpE;

  // A stalled instruction is re-presented; only the advancing cycle may commit.
  assign adv = !Stall & !MCycleStall;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      Flags <= FLAGS_INIT;
    end else begin
      if (FlagWE[1] & CondExE & adv)
        Flags[3:2] <= ALUFlags[3:2];
      if (FlagWE[0] & CondExE & adv)
        Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Reset forces the stall low even while the held op is still on M_StartE.
  assign start = M_StartE & CondExE & !rst_p;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    MStartO     = 1'b0;
    MCycleStall = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          MStartO     = 1'b1;
          MCycleStall = 1'b1;
          state_nx    = RUN;
        end
      end
      RUN: begin
        MCycleStall = 1'b1;
        if (MCycleDone)
          state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

`ifdef COND_PERF_CNT_EN
  logic any_ctl;

  assign any_ctl = PCSE | RegWE | MemWE | M_StartE | (|FlagWE);

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      CondFailCnt <= '0;
      MStallCnt   <= '0;
    end else begin
      if (!CondExE & any_ctl & adv)
        CondFailCnt <= CondFailCnt + CNT_W'(1);
      if (MCycleStall)
        MStallCnt <= MStallCnt + CNT_W'(1);
    end
  end
`else
  assign CondFailCnt = '0;
  assign MStallCnt   = '0;
`endif

endmodule

// File: tb/tb_cond_unit_e.sv
// Directed scoreboard bench for cond_unit_e (FLAGS_INIT=0100, CNT_W=4).
module tb_cond_unit_e;

  localparam int CW = 4;

  localparam int S_CX  = 0;
  localparam int S_PC  = 1;
  localparam int S_RW  = 2;
  localparam int S_MW  = 3;
  localparam int S_MWG = 4;
  localparam int S_MS  = 5;
  localparam int S_OP  = 6;
  localparam int S_STL = 7;
  localparam int S_FL  = 8;
  localparam int S_CFC = 9;
  localparam int S_MSC = 10;

  logic          clk = 1'b0;
  logic          rst_p;
  logic          Stall;
  logic [3:0]    CondE;
  logic [1:0]    FlagWE;
  logic          PCSE;
  logic          RegWE;
  logic          MemWE;
  logic          NoWriteE;
  logic          M_StartE;
  logic          MCycleOpE;
  logic          MWriteE;
  logic [3:0]    ALUFlags;
  logic          MCycleDone;
  logic          CondExE;
  logic          PCSrcE;
  logic          RegWriteE;
  logic          MemWriteE;
  logic          MWriteGE;
  logic          MStartO;
  logic          MCycleOpO;
  logic          MCycleStall;
  logic [3:0]    Flags;
  logic [CW-1:0] CondFailCnt;
  logic [CW-1:0] MStallCnt;

  cond_unit_e #(
    .FLAGS_INIT(4'b0100),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst_p      (rst_p),
    .Stall      (Stall),
    .CondE      (CondE),
    .FlagWE     (FlagWE),
    .PCSE       (PCSE),
    .RegWE      (RegWE),
    .MemWE      (MemWE),
    .NoWriteE   (NoWriteE),
    .M_StartE   (M_StartE),
    .MCycleOpE  (MCycleOpE),
    .MWriteE    (MWriteE),
    .ALUFlags   (ALUFlags),
    .MCycleDone (MCycleDone),
    .CondExE    (CondExE),
    .PCSrcE     (PCSrcE),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .MWriteGE   (MWriteGE),
    .MStartO    (MStartO),
    .MCycleOpO  (MCycleOpO),
    .MCycleStall(MCycleStall),
    .Flags      (Flags),
    .CondFailCnt(CondFailCnt),
    .MStallCnt  (MStallCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_CX:    return 32'(CondExE);
      S_PC:    return 32'(PCSrcE);
      S_RW:    return 32'(RegWriteE);
      S_MW:    return 32'(MemWriteE);
      S_MWG:   return 32'(MWriteGE);
      S_MS:    return 32'(MStartO);
      S_OP:    return 32'(MCycleOpO);
      S_STL:   return 32'(MCycleStall);
      S_FL:    return 32'(Flags);
      S_CFC:   return 32'(CondFailCnt);
      S_MSC:   return 32'(MStallCnt);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic int pc(input int x);
`ifdef COND_PERF_CNT_EN
    return x % 16;
`else
    return 0 * x;
`endif
  endfunction

  task automatic c(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = 32'(exp);
    sbq.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sel);
      n_vec++;
      assert (o === e.exp) else begin
        n_miss++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    Stall      = 1'b0;
    CondE      = 4'h0;
    FlagWE     = 2'b00;
    PCSE       = 1'b0;
    RegWE      = 1'b0;
    MemWE      = 1'b0;
    NoWriteE   = 1'b0;
    M_StartE   = 1'b0;
    MCycleOpE  = 1'b0;
    MWriteE    = 1'b0;
    ALUFlags   = 4'h0;
    MCycleDone = 1'b0;
  endtask

  logic [15:0] ctab;

  initial begin
    rst_p = 1'b1;
    idle_in();
    #1;
    c("rst_flags", S_FL, 4);
    c("rst_stall", S_STL, 0);
    c("rst_mstart", S_MS, 0);
    c("rst_cfc", S_CFC, 0);
    c("rst_msc", S_MSC, 0);
    step();
    rst_p = 1'b0;

    // EQ with Z set passes
    CondE = 4'h0; RegWE = 1; PCSE = 1; MemWE = 1;
    c("eq_cx", S_CX, 1);
    c("eq_rw", S_RW, 1);
    c("eq_pc", S_PC, 1);
    c("eq_mw", S_MW, 1);
    step();

    // NE with Z set fails; counted once
    CondE = 4'h1;
    c("ne_cx", S_CX, 0);
    c("ne_rw", S_RW, 0);
    c("ne_pc", S_PC, 0);
    c("ne_mw", S_MW, 0);
    c("ne_cfc0", S_CFC, 0);
    step();

    CondE = 4'hE; PCSE = 0; MemWE = 0; NoWriteE = 1;
    FlagWE = 2'b11; ALUFlags = 4'b1001;
    c("nowr_rw", S_RW, 0);
    c("al_cx", S_CX, 1);
    c("ne_cfc1", S_CFC, pc(1));
    step();

    RegWE = 0; NoWriteE = 0;
    Stall = 1; ALUFlags = 4'b0110;
    c("wr_flags", S_FL, 9);
    step();

    Stall = 0; FlagWE = 2'b00;
    ctab = 16'b1101_0110_0101_1010;
    for (int i = 0; i < 16; i++) begin
      CondE = 4'(i);
      c("stall_hold", S_FL, 9);
      c($sformatf("cond_%0h", i), S_CX, int'(ctab[i]));
      step();
    end

    CondE = 4'hE; FlagWE = 2'b10; ALUFlags = 4'b0110;
    step();
    FlagWE = 2'b01; ALUFlags = 4'b1010;
    c("nz_only", S_FL, 5);
    step();
    FlagWE = 2'b11; ALUFlags = 4'b0100;
    c("cv_only", S_FL, 6);
    step();

    CondE = 4'h1; ALUFlags = 4'b1111;
    c("fail_fw_cx", S_CX, 0);
    c("set_z", S_FL, 4);
    step();

    // multicycle op, done 4 cycles after start
    CondE = 4'hE; M_StartE = 1; MCycleOpE = 1; MWriteE = 1;
    c("fail_fw_fl", S_FL, 4);
    c("fail_fw_cfc", S_CFC, pc(2));
    c("mc_start", S_MS, 1);
    c("mc_stl0", S_STL, 1);
    c("mc_mwg0", S_MWG, 0);
    c("mc_op", S_OP, 1);
    step();
    for (int r = 1; r <= 4; r++) begin
      MCycleDone = (r == 4);
      c($sformatf("run_ms%0d", r), S_MS, 0);
      c($sformatf("run_stl%0d", r), S_STL, 1);
      c($sformatf("run_mwg%0d", r), S_MWG, 0);
      c($sformatf("run_fl%0d", r), S_FL, 4);
      c($sformatf("run_msc%0d", r), S_MSC, pc(r));
      step();
    end
    c("done_ms", S_MS, 0);
    c("done_stl", S_STL, 0);
    c("done_mwg", S_MWG, 1);
    c("done_msc", S_MSC, pc(5));
    c("done_fl", S_FL, 4);
    step();

    M_StartE = 0; FlagWE = 2'b00;
    c("post_mwg", S_MWG, 0);
    c("post_stl", S_STL, 0);
    c("post_ms", S_MS, 0);
    c("post_fl", S_FL, 15);
    c("post_msc", S_MSC, pc(5));
    step();
    MCycleDone = 0;
    c("idle_done_stl", S_STL, 0);
    step();

    // failed condition with a multicycle op
    CondE = 4'h1; M_StartE = 1;
    c("cf_cx", S_CX, 0);
    c("cf_ms", S_MS, 0);
    c("cf_stl", S_STL, 0);
    c("cf_mwg", S_MWG, 0);
    c("cf_cfc", S_CFC, pc(2));
    step();
    c("cf_stl2", S_STL, 0);
    c("cf_cfc2", S_CFC, pc(3));
    step();

    // reset in RUN
    M_StartE = 0; CondE = 4'hE;
    FlagWE = 2'b11; ALUFlags = 4'b0011;
    c("cf_cfc3", S_CFC, pc(4));
    step();
    FlagWE = 2'b00; M_StartE = 1;
    c("pre_rst_fl", S_FL, 3);
    c("pre_rst_ms", S_MS, 1);
    step();
    c("pre_rst_stl", S_STL, 1);
    step();
    rst_p = 1;
    #1;
    c("rst_run_stl", S_STL, 0);
    c("rst_run_fl", S_FL, 4);
    c("rst_run_ms", S_MS, 0);
    c("rst_run_cfc", S_CFC, 0);
    c("rst_run_msc", S_MSC, 0);
    step();
    M_StartE = 0;
    step();
    rst_p = 0;
    MCycleDone = 1;
    c("rst_done_stl", S_STL, 0);
    c("rst_done_mwg", S_MWG, 0);
    step();
    MCycleDone = 0;
    c("rst_idle_stl", S_STL, 0);
    c("rst_idle_mwg", S_MWG, 0);
    step();
    MWriteE = 0; MCycleOpE = 0;

    // counter wrap with CNT_W=4
    CondE = 4'h1; RegWE = 1;
    for (int i = 0; i < 16; i++) begin
      c($sformatf("wrap_%0d", i), S_CFC, pc(i));
      step();
    end
    c("wrap_end", S_CFC, 0);
    c("wrap_rw", S_RW, 0);
    step();

    // flushed bubble
    idle_in();
    c("bub_pc", S_PC, 0);
    c("bub_rw", S_RW, 0);
    c("bub_mw", S_MW, 0);
    c("bub_mwg", S_MWG, 0);
    c("bub_ms", S_MS, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
